// File: rtl/pattern_hit_judge.sv
// pattern_hit_judge: judges 4-lane button presses against the beat pattern.
// A beat captures PAT and opens a WINDOW-cycle window; the window closes with
// a one-cycle HIT or MISS pulse that also updates COMBO and SCORE.
// Optional macro PATTERN_JUDGE_PERFECT_EN: hits in the first half of the
// window also pulse PERFECT and score double points.
module pattern_hit_judge #(
  parameter int WINDOW  = 8,
  parameter int SCORE_W = 16,
  parameter int COMBO_W = 8,
  parameter int HIT_PTS = 10
) (
  input  logic               C,
  input  logic               INIT_N,
  input  logic               BEAT,
  input  logic [3:0]         PAT,
  input  logic [3:0]         BTN,
  output logic               HIT,
  output logic               MISS,
  output logic               PERFECT,
  output logic               BUSY,
  output logic [COMBO_W-1:0] COMBO,
  output logic [SCORE_W-1:0] SCORE
);

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

  // cnt counts down the remaining window cycles; 8 bits covers WINDOW up to 255
  localparam logic [7:0] CNT_LOAD = 8'(WINDOW - 1);
  localparam logic [SCORE_W+1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W+1:0] PTS_NORMAL = (SCORE_W + 2)'(HIT_PTS);
`ifdef PATTERN_JUDGE_PERFECT_EN
  localparam logic [7:0] CNT_HALF = 8'(WINDOW / 2);
  localparam logic [SCORE_W+1:0] PTS_PERFECT = (SCORE_W + 2)'(2 * HIT_PTS);
`endif

  state_t state_reg, state_next;
  logic [3:0] exp_reg, acc_reg, btn_q_reg;
  logic [7:0] cnt_reg;
  logic hit_reg, miss_reg, perfect_reg;
  logic [COMBO_W-1:0] combo_reg, combo_next;
  logic [SCORE_W-1:0] score_reg, score_next;

  logic [3:0] rise, nxt;
  logic is_open, wrong_key, complete, timeout;
  logic dec_hit, dec_miss, decided, miss_next, perfect_next;
  logic [SCORE_W+1:0] score_add, score_sum;

  // State register; reset aborts any open window without a pulse
  always_ff @(posedge C) begin
    if (!INIT_N) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Judgement of the current window cycle plus combo/score update values
  always_comb begin
    is_open   = (state_reg == OPEN);
    rise      = BTN & ~btn_q_reg;
    nxt       = acc_reg | rise;
    wrong_key = |(nxt & ~exp_reg);
    complete  = (nxt == exp_reg);
    timeout   = (cnt_reg == 8'd0);
    // a wrong key beats a simultaneous completion
    dec_hit   = is_open && !wrong_key && complete;
    dec_miss  = is_open && (wrong_key || (!complete && timeout));
    decided   = dec_hit || dec_miss;
    // a new beat on an undecided window forfeits the old pattern
    miss_next = dec_miss || (is_open && BEAT && !decided);
`ifdef PATTERN_JUDGE_PERFECT_EN
    perfect_next = dec_hit && (cnt_reg >= CNT_HALF);
    score_add    = perfect_next ? PTS_PERFECT : PTS_NORMAL;
`else
    perfect_next = 1'b0;
    score_add    = PTS_NORMAL;
`endif
    score_sum  = {2'b00, score_reg} + score_add;
    combo_next = combo_reg;
    score_next = score_reg;
    if (miss_next) begin
      combo_next = '0;
    end else if (dec_hit) begin
      if (combo_reg != {COMBO_W{1'b1}}) combo_next = combo_reg + COMBO_W'(1);
      score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end
  end

  // Next state: a beat always (re)opens unless it is a rest beat
  always_comb begin
    state_next = state_reg;
    if (BEAT)         state_next = (PAT != 4'b0000) ? OPEN : IDLE;
    else if (decided) state_next = IDLE;
  end

  // Outputs are the registered pulses and counters; BUSY mirrors the state
  always_comb begin
    BUSY    = (state_reg == OPEN);
    HIT     = hit_reg;
    MISS    = miss_reg;
    PERFECT = perfect_reg;
    COMBO   = combo_reg;
    SCORE   = score_reg;
  end

  // Window datapath, edge detector, result pulses and counters
  always_ff @(posedge C) begin
    if (!INIT_N) begin
      exp_reg     <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      btn_q_reg   <= '0;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      perfect_reg <= 1'b0;
      combo_reg   <= '0;
      score_reg   <= '0;
    end else begin
      btn_q_reg   <= BTN;
      hit_reg     <= dec_hit;
      miss_reg    <= miss_next;
      perfect_reg <= perfect_next;
      combo_reg   <= combo_next;
      score_reg   <= score_next;
      if (BEAT) begin
        // presses in the beat cycle itself do not count for the new pattern
        exp_reg <= PAT;
        acc_reg <= '0;
        cnt_reg <= CNT_LOAD;
      end else if (is_open && !decided) begin
        acc_reg <= nxt;
        cnt_reg <= cnt_reg - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_hit_judge.sv
// Testbench for pattern_hit_judge: directed scenarios followed by random
// beats/presses, checked by a scoreboard against a rule-level model.
// Honours PATTERN_JUDGE_PERFECT_EN when the design is built with it.
module tb_pattern_hit_judge;

  localparam int WINDOW  = 8;
  localparam int SCORE_W = 8;
  localparam int COMBO_W = 2;
  localparam int HIT_PTS = 10;
  localparam int SMAX = (1 << SCORE_W) - 1;
  localparam int CMAX = (1 << COMBO_W) - 1;
`ifdef PATTERN_JUDGE_PERFECT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic C = 1'b0;
  logic INIT_N = 1'b0;
  logic BEAT = 1'b0;
  logic [3:0] PAT = 4'b0000;
  logic [3:0] BTN = 4'b0000;
  logic HIT, MISS, PERFECT, BUSY;
  logic [COMBO_W-1:0] COMBO;
  logic [SCORE_W-1:0] SCORE;

  pattern_hit_judge #(
    .WINDOW(WINDOW), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W), .HIT_PTS(HIT_PTS)
  ) dut (
    .C(C), .INIT_N(INIT_N), .BEAT(BEAT), .PAT(PAT), .BTN(BTN),
    .HIT(HIT), .MISS(MISS), .PERFECT(PERFECT), .BUSY(BUSY),
    .COMBO(COMBO), .SCORE(SCORE)
  );

  always #5 C = ~C;

  typedef struct {
    int due;
    bit hit;
    bit perf;
    int combo;
    int score;
  } exp_t;

  exp_t exp_q[$];
  bit   busy_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  // reference model: the window as a set of wanted lanes, lanes pressed so
  // far, and how many window cycles have already elapsed
  bit       m_open = 1'b0;
  bit [3:0] m_pat = 4'b0000;
  bit [3:0] m_got = 4'b0000;
  bit [3:0] m_prev = 4'b0000;
  int       m_elapsed = 0;
  int       m_combo = 0;
  int       m_score = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Drive one cycle's inputs and predict what the following edge produces
  task automatic step(input bit rst_n, input bit beat, input bit [3:0] pat, input bit [3:0] btn);
    bit [3:0] press;
    int outcome;  // 0 none, 1 hit, 2 miss
    bit perf;
    exp_t e;
    @(negedge C);
    INIT_N = rst_n;
    BEAT = beat;
    PAT = pat;
    BTN = btn;
    if (!rst_n) begin
      m_open = 1'b0;
      m_prev = 4'b0000;
      m_combo = 0;
      m_score = 0;
      busy_q.push_back(1'b0);
      return;
    end
    press = btn & ~m_prev;
    m_prev = btn;
    outcome = 0;
    perf = 1'b0;
    if (m_open) begin
      m_got = m_got | press;
      if ((m_got & ~m_pat) != 4'b0000) outcome = 2;
      else if (m_got == m_pat) begin
        outcome = 1;
        perf = FEAT && (m_elapsed < WINDOW - WINDOW / 2);
      end else if (m_elapsed == WINDOW - 1) outcome = 2;
      else m_elapsed++;
      if (beat && outcome == 0) outcome = 2;
    end
    if (outcome == 1) begin
      m_combo = (m_combo < CMAX) ? m_combo + 1 : CMAX;
      m_score = m_score + (perf ? 2 * HIT_PTS : HIT_PTS);
      if (m_score > SMAX) m_score = SMAX;
    end else if (outcome == 2) begin
      m_combo = 0;
    end
    if (outcome != 0) begin
      e.due = edge_cnt + 1;
      e.hit = (outcome == 1);
      e.perf = perf;
      e.combo = m_combo;
      e.score = m_score;
      exp_q.push_back(e);
    end
    if (beat) begin
      m_open = (pat != 4'b0000);
      m_pat = pat;
      m_got = 4'b0000;
      m_elapsed = 0;
    end else if (outcome != 0) begin
      m_open = 1'b0;
    end
    busy_q.push_back(m_open);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic check_cleared(input string tag);
    @(posedge C);
    #2;
    chk({tag, "_hit"}, int'(HIT), 0);
    chk({tag, "_miss"}, int'(MISS), 0);
    chk({tag, "_perfect"}, int'(PERFECT), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_combo"}, int'(COMBO), 0);
    chk({tag, "_score"}, int'(SCORE), 0);
  endtask

  // Monitor: compares BUSY every cycle and each result pulse with the scoreboard
  always @(posedge C) begin
    exp_t e;
    bit b;
    edge_cnt++;
    #1;
    if (busy_q.size() > 0) begin
      b = busy_q.pop_front();
      chk("busy", int'(BUSY), int'(b));
    end
    if (PERFECT === 1'b1 && HIT !== 1'b1) chk("perfect_without_hit", 1, 0);
    if (HIT === 1'b1 || MISS === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_edge", edge_cnt, e.due);
        chk("hit", int'(HIT), int'(e.hit));
        chk("miss", int'(MISS), int'(!e.hit));
        chk("perfect", int'(PERFECT), int'(e.perf));
        chk("combo", int'(COMBO), e.combo);
        chk("score", int'(SCORE), e.score);
        $display("edge %0d: %s%s combo=%0d score=%0d", edge_cnt, HIT ? "hit" : "miss",
                 PERFECT ? "+perfect" : "", COMBO, SCORE);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      e = exp_q.pop_front();
      chk("pulse_missing", 0, 1);
    end
  end

  initial begin
    int r;
    bit [3:0] btn_r;
    // reset held two cycles while inputs toggle
    step(1'b0, 1'b1, 4'b0100, 4'b1111);
    step(1'b0, 1'b0, 4'b0011, 4'b0000);
    check_cleared("reset");
    idle(2);
    // correct hit: press three cycles after the beat
    step(1'b1, 1'b1, 4'b0100, 4'b0000);
    idle(2);
    step(1'b1, 1'b0, 4'b0000, 4'b0100);
    step(1'b1, 1'b0, 4'b0000, 4'b0100);
    idle(3);
    // wrong key pressed together with a correct one
    step(1'b1, 1'b1, 4'b0011, 4'b0000);
    step(1'b1, 1'b0, 4'b0000, 4'b1001);
    idle(3);
    // timeout with the wanted key held since before the beat
    step(1'b1, 1'b0, 4'b0000, 4'b1000);
    step(1'b1, 1'b1, 4'b1000, 4'b1000);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'b0000, 4'b1000);
    idle(2);
    // overlapping beat forfeits the first pattern; second one is hit
    step(1'b1, 1'b1, 4'b0010, 4'b0000);
    idle(3);
    step(1'b1, 1'b1, 4'b0001, 4'b0000);
    idle(1);
    step(1'b1, 1'b0, 4'b0000, 4'b0001);
    idle(3);
    // rest beat
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    idle(3);
    // late hit at the seventh window cycle
    step(1'b1, 1'b1, 4'b0100, 4'b0000);
    idle(6);
    step(1'b1, 1'b0, 4'b0000, 4'b0100);
    idle(2);
    // run of early hits: combo and score saturate
    for (int i = 0; i < 28; i++) begin
      step(1'b1, 1'b1, 4'b0001, 4'b0000);
      step(1'b1, 1'b0, 4'b0000, 4'b0001);
      idle(2);
    end
    // reset in the middle of a window: no pulse, everything cleared
    step(1'b1, 1'b1, 4'b1111, 4'b0000);
    idle(2);
    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_cleared("abort");
    idle(2);
    // random traffic, biased towards pressing the wanted lanes
    btn_r = 4'b0000;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) btn_r = 4'b0000;
      else if (r == 1) btn_r = 4'($urandom_range(0, 15));
      else if (r == 2 || r == 3) btn_r = btn_r | m_pat;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 15)), btn_r);
    end
    idle(WINDOW + 4);
    @(posedge C);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
